// File: rtl/mem_ctrl_banked.sv
// Banked memory controller with per-bank open-row tracking.
// Optional even parity per word when MC_PARITY_EN is defined.
module mem_ctrl_banked #(
  parameter int N     = 8,
  parameter int R     = 4,
  parameter int C     = 4,
  parameter int B     = 2,
  parameter int T_ACT = 2,
  parameter int T_PRE = 1,
  localparam int BW = (B > 1) ? $clog2(B) : 1,
  localparam int RW = (R > 1) ? $clog2(R) : 1,
  localparam int CW = (C > 1) ? $clog2(C) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rw,
  input  logic [BW-1:0] req_bank,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  input  logic [N-1:0]  req_wdata,
  input  logic          perr_inject,
  output logic [N-1:0]  rd_data,
  output logic          rd_valid,
  output logic          wr_ack,
  output logic          addr_err,
  output logic          rd_perr,
  output logic [15:0]   hit_cnt
);

  localparam int DEPTH = B * R * C;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX  = (T_ACT > T_PRE) ? T_ACT : T_PRE;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_ACCESS
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic          r_rw;
  logic [BW-1:0] r_bank;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [N-1:0]  r_wdata;
  logic [B-1:0]  r_open;
  logic [RW-1:0] r_orow [B];
  logic [N-1:0]  r_mem [DEPTH];

  logic          w_accept;
  logic          w_range_ok;
  logic          w_hit;
  logic          w_wr_en;
  logic [IW-1:0] w_idx;

`ifdef MC_PARITY_EN
  logic          r_inj;
  logic          r_par [DEPTH];
`else
  logic          w_unused_inj;
  assign w_unused_inj = perr_inject;
`endif

  assign req_ready  = (r_state == S_IDLE) && cs;
  assign w_accept   = req_valid && req_ready;
  assign w_range_ok = (32'(req_bank) < B) &&
                      (32'(req_row) < R) &&
                      (32'(req_col) < C);
  assign w_hit      = r_open[req_bank] &&
                      (r_orow[req_bank] == req_row);
  assign w_wr_en    = (r_state == S_ACCESS) && !r_rw;
  assign w_idx      = IW'((32'(r_bank) * 32'(R) + 32'(r_row))
                          * 32'(C) + 32'(r_col));

  // Request FSM, bank open-row state and registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rw     <= 1'b0;
      r_bank   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_wdata  <= '0;
      r_open   <= '0;
      for (int i = 0; i < B; i++) r_orow[i] <= '0;
`ifdef MC_PARITY_EN
      r_inj    <= 1'b0;
`endif
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      addr_err <= 1'b0;
      rd_perr  <= 1'b0;
      hit_cnt  <= '0;
    end else begin
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      addr_err <= 1'b0;
      rd_perr  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rw    <= req_rw;
            r_bank  <= req_bank;
            r_row   <= req_row;
            r_col   <= req_col;
            r_wdata <= req_wdata;
`ifdef MC_PARITY_EN
            r_inj   <= perr_inject;
`endif
            if (!w_range_ok) begin
              addr_err <= 1'b1;
            end else if (w_hit) begin
              r_state <= S_ACCESS;
              if (hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            end else if (!r_open[req_bank]) begin
              r_state <= S_ACT;
              r_cnt   <= TW'(T_ACT - 1);
            end else begin
              r_state <= S_PRE;
              r_cnt   <= TW'(T_PRE - 1);
            end
          end
        end
        S_PRE: begin
          if (r_cnt == '0) begin
            r_open[r_bank] <= 1'b0;
            r_state        <= S_ACT;
            r_cnt          <= TW'(T_ACT - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ACT: begin
          if (r_cnt == '0) begin
            r_open[r_bank] <= 1'b1;
            r_orow[r_bank] <= r_row;
            r_state        <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          r_state <= S_IDLE;
          if (r_rw) begin
            rd_data  <= r_mem[w_idx];
            rd_valid <= 1'b1;
`ifdef MC_PARITY_EN
            rd_perr  <= (^r_mem[w_idx]) ^ r_par[w_idx];
`endif
          end else begin
            wr_ack <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage array commit at the edge that ends a write ACCESS
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= r_wdata;
`ifdef MC_PARITY_EN
      r_par[w_idx] <= (^r_wdata) ^ r_inj;
`endif
    end
  end

endmodule

// File: tb/tb_mem_ctrl_banked.sv
// Bench for mem_ctrl_banked: directed plan plus random traffic
// against a cycle-level behavioural model of the controller.
module tb_mem_ctrl_banked;

  localparam int N = 8, R = 3, C = 4, B = 2;
  localparam int T_ACT = 2, T_PRE = 1;
  localparam int BW = 1, RW = 2, CW = 2;

  logic          clk, rst, cs, req_valid, req_ready, req_rw;
  logic [BW-1:0] req_bank;
  logic [RW-1:0] req_row;
  logic [CW-1:0] req_col;
  logic [N-1:0]  req_wdata, rd_data;
  logic          perr_inject, rd_valid, wr_ack, addr_err, rd_perr;
  logic [15:0]   hit_cnt;

  mem_ctrl_banked #(
    .N(N), .R(R), .C(C), .B(B), .T_ACT(T_ACT), .T_PRE(T_PRE)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_bank(req_bank),
    .req_row(req_row), .req_col(req_col),
    .req_wdata(req_wdata), .perr_inject(perr_inject),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_ack(wr_ack), .addr_err(addr_err),
    .rd_perr(rd_perr), .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;

  // model state: kinds 0 none, 1 read, 2 write, 3 address error
  int       ecnt, busy_until, xk, xe, acc_edge;
  bit       m_acc;
  logic [N-1:0] mmem [B][R][C];
  bit       mknown [B][R][C];
  bit       mpbad [B][R][C];
  bit       mopen [B];
  int       morow [B];
  int       mhits;
  logic [N-1:0] last_rd;
  bit       last_known, last_perr;
  int       pb, pr, pc;
  logic [N-1:0] pd;
  bit       pinj;

  function automatic bit parity_on();
`ifdef MC_PARITY_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               nm, act, exp, ecnt);
    end
  endtask

  task automatic model_step();
    int b, r, c, lat;
    ecnt++;
    m_acc = 1'b0;
    if (rst) begin
      busy_until = 0;
      xk = 0;
      for (int i = 0; i < B; i++) mopen[i] = 1'b0;
      mhits = 0;
      last_rd = '0;
      last_known = 1'b1;
      last_perr = 1'b0;
      return;
    end
    if (xk != 0 && xe == ecnt) begin
      if (xk == 2) begin
        mmem[pb][pr][pc]   = pd;
        mknown[pb][pr][pc] = 1'b1;
        mpbad[pb][pr][pc]  = pinj && parity_on();
      end else if (xk == 1) begin
        last_known = mknown[pb][pr][pc];
        last_rd    = mmem[pb][pr][pc];
        last_perr  = mpbad[pb][pr][pc];
      end
    end
    if ((ecnt - 1) >= busy_until && cs && req_valid) begin
      m_acc = 1'b1;
      acc_edge = ecnt;
      b = int'(req_bank);
      r = int'(req_row);
      c = int'(req_col);
      if (b >= B || r >= R || c >= C) begin
        xk = 3;
        xe = ecnt;
      end else begin
        if (mopen[b] && morow[b] == r) begin
          lat = 2;
          mhits = (mhits < 65535) ? mhits + 1 : 65535;
        end else if (!mopen[b]) begin
          lat = T_ACT + 2;
        end else begin
          lat = T_PRE + T_ACT + 2;
        end
        mopen[b] = 1'b1;
        morow[b] = r;
        xe = ecnt + lat - 1;
        busy_until = xe;
        xk = req_rw ? 1 : 2;
        pb = b; pr = r; pc = c;
        pd = req_wdata;
        pinj = perr_inject;
      end
    end
  endtask

  task automatic check();
    bit erv;
    erv = (xk == 1 && xe == ecnt);
    chk("req_ready", req_ready, (ecnt >= busy_until) && cs);
    chk("rd_valid", rd_valid, erv);
    chk("wr_ack", wr_ack, (xk == 2 && xe == ecnt));
    chk("addr_err", addr_err, (xk == 3 && xe == ecnt));
    chk("hit_cnt", hit_cnt, mhits);
    if (last_known) chk("rd_data", rd_data, last_rd);
    if (erv) chk("rd_perr", rd_perr, last_perr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check();
  endtask

  task automatic issue(input bit rw, input int b, input int r,
                       input int c, input logic [N-1:0] d,
                       input bit inj, input bit drop_cs,
                       output int lat);
    int k;
    lat = -1;
    req_rw = rw;
    req_bank = BW'(b);
    req_row = RW'(r);
    req_col = CW'(c);
    req_wdata = d;
    perr_inject = inj;
    req_valid = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!m_acc && k < 30);
    req_valid = 1'b0;
    if (!m_acc) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    if (drop_cs) cs = 1'b0;
    k = 0;
    while (!(rd_valid || wr_ack || addr_err) && k < 30) begin
      tick();
      k++;
    end
    cs = 1'b1;
    if (rd_valid || wr_ack || addr_err)
      lat = ecnt - acc_edge + 1;
    else
      chk("response_timeout", 0, 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_rd_perr", rd_perr, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    n_chk = 0; n_fail = 0;
    ecnt = 0; busy_until = 0; xk = 0; xe = 0; mhits = 0;
    last_rd = '0; last_known = 1'b1; last_perr = 1'b0;
    rst = 1'b1; cs = 1'b1; req_valid = 1'b0; req_rw = 1'b0;
    req_bank = '0; req_row = '0; req_col = '0;
    req_wdata = '0; perr_inject = 1'b0;
    for (int i = 0; i < B; i++) begin
      mopen[i] = 1'b0;
      morow[i] = 0;
    end
    @(negedge clk);
    reset_pulse();

    issue(0, 0, 1, 2, 8'hA5, 0, 0, lat);
    chk("lat_closed_wr", lat, 4);
    issue(1, 0, 1, 2, 8'h00, 0, 0, lat);
    chk("lat_hit_rd", lat, 2);
    chk("data_A5", rd_data, 8'hA5);
    chk("hits_1", hit_cnt, 1);

    issue(0, 0, 2, 0, 8'h3C, 0, 0, lat);
    chk("lat_miss_wr", lat, 5);
    issue(1, 0, 2, 0, 8'h00, 0, 0, lat);
    chk("lat_hit_rd2", lat, 2);
    chk("data_3C", rd_data, 8'h3C);

    issue(0, 1, 0, 0, 8'h11, 0, 0, lat);
    chk("lat_b1_closed", lat, 4);
    issue(1, 0, 2, 0, 8'h00, 0, 0, lat);
    chk("lat_interleave_hit", lat, 2);
    chk("hits_3", hit_cnt, 3);

    issue(0, 0, 3, 0, 8'hFF, 0, 0, lat);
    chk("lat_addr_err", lat, 1);
    chk("err_no_wr_ack", wr_ack, 0);
    chk("hits_after_err", hit_cnt, 3);
    issue(1, 0, 2, 0, 8'h00, 0, 0, lat);
    chk("lat_after_err", lat, 2);
    chk("data_unchanged", rd_data, 8'h3C);

    cs = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cs_low_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    cs = 1'b1;

    issue(0, 1, 1, 1, 8'h77, 0, 1, lat);
    chk("lat_cs_drop", lat, 5);
    issue(1, 1, 1, 1, 8'h00, 0, 0, lat);
    chk("data_77", rd_data, 8'h77);

    req_rw = 1'b0; req_bank = 1'b1; req_row = 2'd0;
    req_col = 2'd0; req_wdata = 8'h55; req_valid = 1'b1;
    for (int i = 0; i < 30 && !m_acc; i++) tick();
    req_valid = 1'b0;
    tick();
    reset_pulse();
    issue(1, 0, 2, 0, 8'h00, 0, 0, lat);
    chk("lat_after_rst", lat, 4);
    chk("data_after_rst", rd_data, 8'h3C);
    issue(1, 1, 0, 0, 8'h00, 0, 0, lat);
    chk("abandoned_wr", rd_data, 8'h11);

    issue(0, 0, 0, 0, 8'h0F, 1, 0, lat);
    issue(1, 0, 0, 0, 8'h00, 0, 0, lat);
    chk("perr_inj", rd_perr, parity_on());
    issue(0, 0, 0, 1, 8'h0F, 0, 0, lat);
    issue(1, 0, 0, 1, 8'h00, 0, 0, lat);
    chk("perr_clean", rd_perr, 0);

    for (int b = 0; b < B; b++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          issue(0, b, r, c, N'($urandom), 1'($urandom), 0, lat);

    for (int i = 0; i < 4000; i++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(299) == 0) rst = 1'b1;
      cs = ($urandom_range(9) != 0);
      req_valid = ($urandom_range(3) != 0);
      req_rw = 1'($urandom);
      req_bank = BW'($urandom);
      req_row = RW'($urandom);
      req_col = CW'($urandom);
      req_wdata = N'($urandom);
      perr_inject = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    cs = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
